mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port (read-only) and the MEM-stage data port (read/write). Arbitration gives data priority, with a starvation bound for fetch. Requests are serialised through a request/acknowledge handshake to the memory. A one-cycle `ready` pulse back to each requester releases that requester's pipeline stall. The block sits between the IF/MEM stages and the unified memory, replacing separate instruction and data memories.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch port and the data port.
// Data has priority; fetch wins a tie after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             if_req_i,
    input  logic [31:0]      if_addr_i,
    output logic [31:0]      if_rdata_o,
    output logic             if_ready_o,
    input  logic             dm_req_i,
    input  logic             dm_we_i,
    input  logic [1:0]       dm_wrbits_i,
    input  logic [2:0]       dm_rbits_i,
    input  logic [31:0]      dm_addr_i,
    input  logic [31:0]      dm_wdata_i,
    output logic [31:0]      dm_rdata_o,
    output logic             dm_ready_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [1:0]       mem_wrbits_o,
    output logic [2:0]       mem_rbits_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    input  logic             mem_ack_i,
    output logic [CNT_W-1:0] if_grants_o,
    output logic [CNT_W-1:0] dm_grants_o
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [1:0]        mem_wrbits_q, mem_wrbits_d;
    logic [2:0]        mem_rbits_q, mem_rbits_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [CNT_W-1:0]  if_grants_q, if_grants_d;
    logic [CNT_W-1:0]  dm_grants_q, dm_grants_d;
    logic              grant_i, grant_d, starved;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wrbits_q <= '0;
            mem_rbits_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ready_q   <= 1'b0;
            dm_ready_q   <= 1'b0;
            if_grants_q  <= '0;
            dm_grants_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_wrbits_q <= mem_wrbits_d;
            mem_rbits_q  <= mem_rbits_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ready_q   <= if_ready_d;
            dm_ready_q   <= dm_ready_d;
            if_grants_q  <= if_grants_d;
            dm_grants_q  <= dm_grants_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_wrbits_d = mem_wrbits_q;
        mem_rbits_d  = mem_rbits_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ready_d   = 1'b0;
        dm_ready_d   = 1'b0;
        if_grants_d  = if_grants_q;
        dm_grants_d  = dm_grants_q;
        starved      = (starve_q == SW'(STARVE_LIMIT));
        grant_i      = 1'b0;
        grant_d      = 1'b0;

        case (state_q)
            IDLE: begin
                grant_i = if_req_i && (!dm_req_i || starved);
                grant_d = dm_req_i && !grant_i;
                if (grant_d) begin
                    state_d      = D_ACC;
                    mem_req_d    = 1'b1;
                    mem_we_d     = dm_we_i;
                    mem_wrbits_d = dm_wrbits_i;
                    mem_rbits_d  = dm_rbits_i;
                    mem_addr_d   = dm_addr_i;
                    mem_wdata_d  = dm_wdata_i;
                    if (if_req_i && !starved)
                        starve_d = starve_q + SW'(1);
                    if (dm_grants_q != '1)
                        dm_grants_d = dm_grants_q + CNT_W'(1);
                end else if (grant_i) begin
                    // Fetch is always a plain word read
                    state_d      = I_ACC;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_wrbits_d = 2'b00;
                    mem_rbits_d  = 3'b000;
                    mem_addr_d   = if_addr_i;
                    mem_wdata_d  = '0;
                    starve_d     = '0;
                    if (if_grants_q != '1)
                        if_grants_d = if_grants_q + CNT_W'(1);
                end
            end
            I_ACC: begin
                if (mem_ack_i) begin
                    if_rdata_d = mem_rdata_i;
                    if_ready_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            D_ACC: begin
                if (mem_ack_i) begin
                    dm_rdata_d = mem_rdata_i;
                    dm_ready_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            // Dead cycle so a requester still high during ready is not re-granted
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign if_rdata_o   = if_rdata_q;
    assign if_ready_o   = if_ready_q;
    assign dm_rdata_o   = dm_rdata_q;
    assign dm_ready_o   = dm_ready_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wrbits_o = mem_wrbits_q;
    assign mem_rbits_o  = mem_rbits_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign if_grants_o  = if_grants_q;
    assign dm_grants_o  = dm_grants_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, inline expected-value checks.
// A second instance with 2-bit counters shares all inputs to exercise counter saturation.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [1:0]  dm_wrbits;
    logic [2:0]  dm_rbits;

    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_req, mem_we;
    logic [1:0]  mem_wrbits;
    logic [2:0]  mem_rbits;
    logic [15:0] if_grants, dm_grants;

    logic [31:0] s_if_rdata, s_dm_rdata, s_mem_addr, s_mem_wdata;
    logic        s_if_ready, s_dm_ready, s_mem_req, s_mem_we;
    logic [1:0]  s_mem_wrbits;
    logic [2:0]  s_mem_rbits;
    logic [1:0]  s_if_grants, s_dm_grants;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_wrbits_i(dm_wrbits), .dm_rbits_i(dm_rbits),
        .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_wrbits_o(mem_wrbits), .mem_rbits_o(mem_rbits),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .if_grants_o(if_grants), .dm_grants_o(dm_grants)
    );

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(s_if_rdata), .if_ready_o(s_if_ready),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_wrbits_i(dm_wrbits), .dm_rbits_i(dm_rbits),
        .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_rdata_o(s_dm_rdata), .dm_ready_o(s_dm_ready),
        .mem_req_o(s_mem_req), .mem_we_o(s_mem_we), .mem_wrbits_o(s_mem_wrbits), .mem_rbits_o(s_mem_rbits),
        .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .if_grants_o(s_if_grants), .dm_grants_o(s_dm_grants)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        n_tests++;
        if ({mem_req, mem_we, mem_wrbits, mem_rbits} !== 7'd0) begin
            n_fail++; $display("FAIL reset_mem_ctrl got %b exp 0", {mem_req, mem_we, mem_wrbits, mem_rbits});
        end
        n_tests++;
        if ({mem_addr, mem_wdata} !== 64'd0) begin
            n_fail++; $display("FAIL reset_mem_data got %h exp 0", {mem_addr, mem_wdata});
        end
        n_tests++;
        if ({if_ready, dm_ready, if_rdata, dm_rdata} !== 66'd0) begin
            n_fail++; $display("FAIL reset_resp got %h exp 0", {if_ready, dm_ready, if_rdata, dm_rdata});
        end
        n_tests++;
        if ({if_grants, dm_grants} !== 32'd0) begin
            n_fail++; $display("FAIL reset_grants got %h exp 0", {if_grants, dm_grants});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch_only;
        if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h2008_0005;
        tick();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, if_ready} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
            n_fail++; $display("FAIL fetch_cmd got req=%b we=%b addr=%h rdy=%b exp req=1 we=0 addr=40 rdy=0",
                               mem_req, mem_we, mem_addr, if_ready);
        end
        tick();
        mem_ack = 1'b1;
        tick();
        n_tests++;
        if ({if_ready, dm_ready, if_rdata} !== {1'b1, 1'b0, 32'h2008_0005}) begin
            n_fail++; $display("FAIL fetch_ready got if_rdy=%b dm_rdy=%b rdata=%h exp 1 0 20080005",
                               if_ready, dm_ready, if_rdata);
        end
        n_tests++;
        if ({mem_req, if_grants} !== {1'b0, 16'd1}) begin
            n_fail++; $display("FAIL fetch_grants got req=%b grants=%0d exp req=0 grants=1", mem_req, if_grants);
        end
        mem_ack = 1'b0; if_req = 1'b0; mem_rdata = 32'h0;
        tick();
        n_tests++;
        if ({if_ready, if_rdata} !== {1'b0, 32'h2008_0005}) begin
            n_fail++; $display("FAIL fetch_hold got rdy=%b rdata=%h exp 0 20080005", if_ready, if_rdata);
        end
    endtask

    task automatic test_simultaneous;
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b1; dm_wrbits = 2'b00; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        tick();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL simul_d_cmd got req=%b we=%b addr=%h wdata=%h exp 1 1 100 deadbeef",
                               mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        n_tests++;
        if ({dm_ready, if_ready} !== 2'b10) begin
            n_fail++; $display("FAIL simul_d_ready got dm=%b if=%b exp dm=1 if=0", dm_ready, if_ready);
        end
        mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h200, 32'h0}) begin
            n_fail++; $display("FAIL simul_i_cmd got req=%b we=%b addr=%h wdata=%h exp 1 0 200 0",
                               mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        n_tests++;
        if ({if_ready, dm_ready, if_rdata} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL simul_i_ready got if=%b dm=%b rdata=%h exp 1 0 0badf00d",
                               if_ready, dm_ready, if_rdata);
        end
        mem_ack = 1'b0; if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation;
        logic exp_i;
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int g = 0; g < 6; g++) begin
            exp_i = (g == 4);
            tick();
            n_tests++;
            if (mem_addr !== (exp_i ? 32'h400 : 32'h300)) begin
                n_fail++; $display("FAIL starve_grant%0d got addr=%h exp %h", g, mem_addr,
                                   exp_i ? 32'h400 : 32'h300);
            end
            mem_ack = 1'b1; mem_rdata = 32'h1000 + g;
            tick();
            n_tests++;
            if ({if_ready, dm_ready} !== {exp_i, ~exp_i}) begin
                n_fail++; $display("FAIL starve_ready%0d got if=%b dm=%b exp if=%b dm=%b", g,
                                   if_ready, dm_ready, exp_i, ~exp_i);
            end
            mem_ack = 1'b0;
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        n_tests++;
        if ({if_grants, dm_grants} !== {16'd3, 16'd6}) begin
            n_fail++; $display("FAIL starve_counts got if=%0d dm=%0d exp if=3 dm=6", if_grants, dm_grants);
        end
    endtask

    task automatic test_long_latency;
        mem_ack = 1'b1;
        tick();
        n_tests++;
        if ({mem_req, if_ready, dm_ready} !== 3'b000) begin
            n_fail++; $display("FAIL stray_ack got req=%b if=%b dm=%b exp 000", mem_req, if_ready, dm_ready);
        end
        mem_ack = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_rbits = 3'b101; dm_addr = 32'h500; mem_rdata = 32'h1234_5678;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_tests++;
            if ({mem_req, mem_addr, dm_ready} !== {1'b1, 32'h500, 1'b0}) begin
                n_fail++; $display("FAIL latency_hold_c%0d got req=%b addr=%h rdy=%b exp 1 500 0", c,
                                   mem_req, mem_addr, dm_ready);
            end
            if (c == 1) begin
                n_tests++;
                if (mem_rbits !== 3'b101) begin
                    n_fail++; $display("FAIL latency_rbits got %b exp 101", mem_rbits);
                end
            end
        end
        mem_ack = 1'b1;
        tick();
        n_tests++;
        if ({dm_ready, mem_req, dm_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            n_fail++; $display("FAIL latency_ready got rdy=%b req=%b rdata=%h exp 1 0 12345678",
                               dm_ready, mem_req, dm_rdata);
        end
        mem_ack = 1'b0; dm_req = 1'b0; dm_rbits = 3'b000;
        tick();
        n_tests++;
        if (dm_ready !== 1'b0) begin
            n_fail++; $display("FAIL latency_pulse got rdy=%b exp 0", dm_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h600; dm_wdata = 32'h7777_7777;
        tick();
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre got req=%b exp 1", mem_req);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({mem_req, dm_ready, mem_addr, dm_grants} !== {1'b0, 1'b0, 32'h0, 16'd0}) begin
            n_fail++; $display("FAIL rstmid_now got req=%b rdy=%b addr=%h grants=%0d exp 0 0 0 0",
                               mem_req, dm_ready, mem_addr, dm_grants);
        end
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        rst = 1'b0;
        dm_req = 1'b1; dm_addr = 32'h700; mem_rdata = 32'hCAFE_0001;
        tick();
        n_tests++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h700}) begin
            n_fail++; $display("FAIL rstmid_regrant got req=%b we=%b addr=%h exp 1 0 700",
                               mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        n_tests++;
        if ({dm_ready, dm_rdata} !== {1'b1, 32'hCAFE_0001}) begin
            n_fail++; $display("FAIL rstmid_done got rdy=%b rdata=%h exp 1 cafe0001", dm_ready, dm_rdata);
        end
        mem_ack = 1'b0; dm_req = 1'b0;
        tick();
        n_tests++;
        if (dm_grants !== 16'd1) begin
            n_fail++; $display("FAIL rstmid_grants got %0d exp 1", dm_grants);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 3; i++) begin
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800 + 32'(i * 4);
            tick();
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0; dm_req = 1'b0;
            tick();
        end
        n_tests++;
        if (dm_grants !== 16'd4) begin
            n_fail++; $display("FAIL sat_wide got %0d exp 4", dm_grants);
        end
        n_tests++;
        if ({s_dm_grants, s_if_grants} !== {2'd3, 2'd0}) begin
            n_fail++; $display("FAIL sat_narrow got dm=%0d if=%0d exp dm=3 if=0", s_dm_grants, s_if_grants);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; dm_wrbits = '0; dm_rbits = '0;
        tick();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_long_latency();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
